// File: rtl/floo_axis_noc_bridge_multi_vc.sv
// Credit-based bridge between NumVc NoC virtual channels and one AXI-Stream link.
// Optional SVA checks are compiled when FLOO_AXIS_BRIDGE_ASSERT_EN is defined.
module floo_axis_noc_bridge_multi_vc #(
  parameter int unsigned NumVc     = 2,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned RxDepth   = 3,
  parameter int unsigned VcW       = (NumVc > 1) ? $clog2(NumVc) : 1,
  parameter int unsigned CntW      = $clog2(RxDepth + 1),
  parameter int unsigned TdataW    = DataWidth + 2 * VcW + 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NumVc-1:0]           noc_in_valid_i,
  output logic [NumVc-1:0]           noc_in_ready_o,
  input  logic [NumVc*DataWidth-1:0] noc_in_data_i,
  output logic [NumVc-1:0]           noc_out_valid_o,
  input  logic [NumVc-1:0]           noc_out_ready_i,
  output logic [NumVc*DataWidth-1:0] noc_out_data_o,
  output logic                       axis_out_tvalid_o,
  input  logic                       axis_out_tready_i,
  output logic [TdataW-1:0]          axis_out_tdata_o,
  input  logic                       axis_in_tvalid_i,
  output logic                       axis_in_tready_o,
  input  logic [TdataW-1:0]          axis_in_tdata_i,
  output logic                       err_o
);
  localparam int unsigned PtrW      = (RxDepth > 1) ? $clog2(RxDepth) : 1;
  localparam int unsigned IsDataBit = DataWidth + VcW;

  logic [NumVc-1:0][CntW-1:0] credit_q, credit_d, pend_q, pend_d, cnt_q, cnt_d;
  logic [NumVc-1:0][PtrW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [DataWidth-1:0]       mem_q [NumVc][RxDepth];
  logic [VcW-1:0]             rr_q, rr_d;
  logic                       out_valid_q, out_valid_d;
  logic [TdataW-1:0]          out_q, out_d;
  logic                       err_q, err_d;

  logic                 out_is_data, tx_fire, load;
  logic [VcW-1:0]       out_vc;
  logic                 rx_fire, in_is_data, in_crd_vld, in_vc_ok;
  logic [VcW-1:0]       in_vc, in_crd_vc;
  logic [DataWidth-1:0] in_data;
  logic [NumVc-1:0]     eligible, push, pop, rx_drop, crd_dec, crd_inc, pend_take;
  logic                 any_elig, found_hi, any_pend, crd_ovf;
  logic [VcW-1:0]       grant, grant_hi, grant_lo, pend_vc;
  logic [TdataW-1:0]    beat;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(RxDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign out_is_data       = out_q[IsDataBit];
  assign out_vc            = out_q[IsDataBit-1 -: VcW];
  assign tx_fire           = out_valid_q && axis_out_tready_i;
  assign load              = !rst_i && (!out_valid_q || axis_out_tready_i);
  assign axis_out_tvalid_o = out_valid_q;
  assign axis_out_tdata_o  = out_q;
  assign err_o             = err_q;

  assign axis_in_tready_o = !rst_i;
  assign rx_fire          = axis_in_tvalid_i && axis_in_tready_o;
  assign in_crd_vld       = axis_in_tdata_i[TdataW-1];
  assign in_crd_vc        = axis_in_tdata_i[TdataW-2 -: VcW];
  assign in_is_data       = axis_in_tdata_i[IsDataBit];
  assign in_vc            = axis_in_tdata_i[IsDataBit-1 -: VcW];
  assign in_data          = axis_in_tdata_i[DataWidth-1:0];
  assign in_vc_ok         = 32'(in_vc) < NumVc;

  // TX: arbitration, credit piggyback and output register next state
  always_comb begin
    eligible = '0;
    for (int v = 0; v < NumVc; v++) begin
      // The register occupant has not yet consumed its credit.
      eligible[v] = noc_in_valid_i[v] &&
                    (credit_q[v] > CntW'(out_valid_q && out_is_data && (out_vc == VcW'(v))));
    end
    any_elig = |eligible;
    found_hi = 1'b0;
    grant_hi = '0;
    grant_lo = '0;
    for (int v = NumVc - 1; v >= 0; v--) begin
      if (eligible[v]) begin
        grant_lo = VcW'(v);
        if (v >= int'(rr_q)) begin
          grant_hi = VcW'(v);
          found_hi = 1'b1;
        end
      end
    end
    grant = found_hi ? grant_hi : grant_lo;

    any_pend = 1'b0;
    pend_vc  = '0;
    for (int v = NumVc - 1; v >= 0; v--) begin
      if (pend_q[v] != '0) begin
        any_pend = 1'b1;
        pend_vc  = VcW'(v);
      end
    end

    beat                   = '0;
    beat[TdataW-1]         = any_pend;
    beat[TdataW-2 -: VcW]  = pend_vc;
    if (any_elig) begin
      beat[IsDataBit]          = 1'b1;
      beat[IsDataBit-1 -: VcW] = grant;
      beat[DataWidth-1:0]      = noc_in_data_i[int'(grant)*DataWidth +: DataWidth];
    end

    noc_in_ready_o = '0;
    for (int v = 0; v < NumVc; v++) begin
      noc_in_ready_o[v] = load && any_elig && (grant == VcW'(v));
    end

    out_valid_d = out_valid_q;
    out_d       = out_q;
    rr_d        = rr_q;
    if (load) begin
      out_valid_d = any_elig || any_pend;
      if (any_elig || any_pend) out_d = beat;
      if (any_elig) rr_d = (grant == VcW'(NumVc - 1)) ? '0 : grant + VcW'(1);
    end
  end

  // Remote credit and pending-return counters
  always_comb begin
    credit_d  = credit_q;
    pend_d    = pend_q;
    crd_ovf   = 1'b0;
    crd_dec   = '0;
    crd_inc   = '0;
    pend_take = '0;
    for (int v = 0; v < NumVc; v++) begin
      crd_dec[v]   = tx_fire && out_is_data && (out_vc == VcW'(v));
      crd_inc[v]   = rx_fire && in_crd_vld && (in_crd_vc == VcW'(v));
      pend_take[v] = load && any_pend && (pend_vc == VcW'(v));
      if (crd_inc[v] && !crd_dec[v]) begin
        if (credit_q[v] == CntW'(RxDepth)) crd_ovf = 1'b1;
        else credit_d[v] = credit_q[v] + CntW'(1);
      end else if (crd_dec[v] && !crd_inc[v]) begin
        credit_d[v] = credit_q[v] - CntW'(1);
      end
      if (pop[v] && !pend_take[v]) pend_d[v] = pend_q[v] + CntW'(1);
      else if (pend_take[v] && !pop[v]) pend_d[v] = pend_q[v] - CntW'(1);
    end
  end

  // RX demux into per-VC FIFOs
  always_comb begin
    cnt_d           = cnt_q;
    rd_d            = rd_q;
    wr_d            = wr_q;
    push            = '0;
    pop             = '0;
    rx_drop         = '0;
    noc_out_valid_o = '0;
    noc_out_data_o  = '0;
    for (int v = 0; v < NumVc; v++) begin
      noc_out_valid_o[v] = cnt_q[v] != '0;
      noc_out_data_o[v*DataWidth +: DataWidth] = mem_q[v][rd_q[v]];
      pop[v] = noc_out_valid_o[v] && noc_out_ready_i[v];
      if (rx_fire && in_is_data && in_vc_ok && (in_vc == VcW'(v))) begin
        if (cnt_q[v] == CntW'(RxDepth)) rx_drop[v] = 1'b1;
        else push[v] = 1'b1;
      end
      if (push[v]) wr_d[v] = ptr_inc(wr_q[v]);
      if (pop[v]) rd_d[v] = ptr_inc(rd_q[v]);
      if (push[v] && !pop[v]) cnt_d[v] = cnt_q[v] + CntW'(1);
      else if (pop[v] && !push[v]) cnt_d[v] = cnt_q[v] - CntW'(1);
    end
  end

  assign err_d = err_q || crd_ovf || (|rx_drop) || (rx_fire && in_is_data && !in_vc_ok);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      credit_q    <= {NumVc{CntW'(RxDepth)}};
      pend_q      <= '0;
      cnt_q       <= '0;
      rd_q        <= '0;
      wr_q        <= '0;
      rr_q        <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      credit_q    <= credit_d;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      rr_q        <= rr_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int v = 0; v < NumVc; v++) begin
      if (push[v]) mem_q[v][wr_q[v]] <= in_data;
    end
  end

`ifdef FLOO_AXIS_BRIDGE_ASSERT_EN
  logic data_at_zero_credit;
  assign data_at_zero_credit = tx_fire && out_is_data && (credit_q[out_vc] == '0);

  a_tdata_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (axis_out_tvalid_o && !axis_out_tready_i) |=> $stable(axis_out_tdata_o))
    else $error("axis_out_tdata_o changed under backpressure");
  a_no_zero_credit: assert property (@(posedge clk_i) disable iff (rst_i)
    !data_at_zero_credit)
    else $error("data beat sent with zero credit");
  a_no_rx_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    rx_drop == '0)
    else $error("rx fifo overflow");
  a_no_err: assert property (@(posedge clk_i) disable iff (rst_i)
    !err_o)
    else $error("err_o raised");
`endif

endmodule

// File: tb/tb_floo_axis_noc_bridge_multi_vc.sv
// Loopback of two bridges with a queue scoreboard per direction and VC,
// plus directed checks on credits, arbitration, credit-only beats, errors and reset.
module tb_floo_axis_noc_bridge_multi_vc;
  localparam int NV = 2;
  localparam int DW = 16;
  localparam int RD = 2;
  localparam int VW = 1;
  localparam int TW = DW + 2 * VW + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NV-1:0]    a_nin_v, a_nin_r, a_nout_v, a_nout_r;
  logic [NV-1:0]    b_nin_v, b_nin_r, b_nout_v, b_nout_r;
  logic [NV*DW-1:0] a_nin_d, a_nout_d, b_nin_d, b_nout_d;
  logic             ab_tvalid, ab_tready, ba_tvalid, ba_tready;
  logic [TW-1:0]    ab_tdata, ba_tdata;
  logic             b_in_tvalid, b_in_tready;
  logic [TW-1:0]    b_in_tdata;
  logic             inj;
  logic [TW-1:0]    inj_data;
  logic             a_err, b_err;

  // Bench can hijack B's receive port to inject beats.
  assign b_in_tvalid = inj ? 1'b1 : ab_tvalid;
  assign b_in_tdata  = inj ? inj_data : ab_tdata;
  assign ab_tready   = inj ? 1'b0 : b_in_tready;

  floo_axis_noc_bridge_multi_vc #(.NumVc(NV), .DataWidth(DW), .RxDepth(RD)) u_a (
    .clk_i(clk), .rst_i(rst),
    .noc_in_valid_i(a_nin_v), .noc_in_ready_o(a_nin_r), .noc_in_data_i(a_nin_d),
    .noc_out_valid_o(a_nout_v), .noc_out_ready_i(a_nout_r), .noc_out_data_o(a_nout_d),
    .axis_out_tvalid_o(ab_tvalid), .axis_out_tready_i(ab_tready), .axis_out_tdata_o(ab_tdata),
    .axis_in_tvalid_i(ba_tvalid), .axis_in_tready_o(ba_tready), .axis_in_tdata_i(ba_tdata),
    .err_o(a_err)
  );

  floo_axis_noc_bridge_multi_vc #(.NumVc(NV), .DataWidth(DW), .RxDepth(RD)) u_b (
    .clk_i(clk), .rst_i(rst),
    .noc_in_valid_i(b_nin_v), .noc_in_ready_o(b_nin_r), .noc_in_data_i(b_nin_d),
    .noc_out_valid_o(b_nout_v), .noc_out_ready_i(b_nout_r), .noc_out_data_o(b_nout_d),
    .axis_out_tvalid_o(ba_tvalid), .axis_out_tready_i(ba_tready), .axis_out_tdata_o(ba_tdata),
    .axis_in_tvalid_i(b_in_tvalid), .axis_in_tready_o(b_in_tready), .axis_in_tdata_i(b_in_tdata),
    .err_o(b_err)
  );

  int total = 0;
  int bad = 0;
  bit [DW-1:0] exp_q [4][$];  // 0..1: A->B per VC, 2..3: B->A per VC
  logic [NV-1:0] a_acc = '0;
  logic [NV-1:0] b_acc = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic sb_pop(input int q, input logic [DW-1:0] got);
    total++;
    if (exp_q[q].size() == 0) begin
      bad++;
      $display("FAIL sb_q%0d: got %0h want nothing", q, got);
    end else begin
      logic [DW-1:0] want;
      want = exp_q[q].pop_front();
      if (got !== want) begin
        bad++;
        $display("FAIL sb_q%0d: got %0h want %0h", q, got, want);
      end
    end
  endtask

  // Record accepted NoC flits as expected far-side deliveries.
  always @(negedge clk) begin
    #1;
    for (int v = 0; v < NV; v++) begin
      a_acc[v] = a_nin_v[v] && a_nin_r[v];
      b_acc[v] = b_nin_v[v] && b_nin_r[v];
      if (a_acc[v]) exp_q[v].push_back(a_nin_d[v*DW +: DW]);
      if (b_acc[v]) exp_q[2+v].push_back(b_nin_d[v*DW +: DW]);
    end
  end

  // Check every delivered flit against the scoreboard.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      for (int v = 0; v < NV; v++) begin
        if (b_nout_v[v] && b_nout_r[v]) sb_pop(v, b_nout_d[v*DW +: DW]);
        if (a_nout_v[v] && a_nout_r[v]) sb_pop(2 + v, a_nout_d[v*DW +: DW]);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Offer n flits on A's VC; valid stays high if not all were taken.
  task automatic send_a(input int vc, input int n, input int cyc, output int got);
    got = 0;
    @(negedge clk);
    a_nin_v[vc] = 1'b1;
    a_nin_d[vc*DW +: DW] = DW'($urandom);
    for (int c = 0; c < cyc; c++) begin
      @(negedge clk);
      if (a_acc[vc] && got < n) begin
        got++;
        if (got == n) a_nin_v[vc] = 1'b0;
        else a_nin_d[vc*DW +: DW] = DW'($urandom);
      end
    end
  endtask

  task automatic release_a(input int vc, input string name);
    int got;
    got = 0;
    for (int c = 0; c < 15 && got == 0; c++) begin
      @(negedge clk);
      if (a_acc[vc]) begin
        got = 1;
        a_nin_v[vc] = 1'b0;
      end
    end
    chk(name, got, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    int n;
    logic prev;
    logic [TW-1:0] beat;
    a_nin_v = '0; b_nin_v = '0; a_nin_d = '0; b_nin_d = '0;
    a_nout_r = '1; b_nout_r = '1; inj = 1'b0; inj_data = '0;
    beat = '0; prev = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_tvalid", {ab_tvalid, ba_tvalid}, 0);
    chk("rst_tdata_a", ab_tdata, 0);
    chk("rst_tdata_b", ba_tdata, 0);
    chk("rst_nout_valid", {a_nout_v, b_nout_v}, 0);
    chk("rst_nin_ready", {a_nin_r, b_nin_r}, 0);
    chk("rst_err", {a_err, b_err}, 0);

    // Far side stalls VC0: only RxDepth flits can leave.
    b_nout_r[0] = 1'b0;
    send_a(0, 3, 20, got);
    chk("stall_sent", got, RD);
    #1;
    chk("stall_ready_low", a_nin_r[0], 0);
    chk("err_before", b_err, 0);

    // Data beat into B's full VC0 FIFO.
    @(negedge clk);
    inj = 1'b1;
    inj_data = {1'b0, 1'b0, 1'b1, 1'b0, 16'hBEEF};
    @(negedge clk);
    inj = 1'b0;
    #1;
    chk("err_set", b_err, 1);
    idle(5);
    #1;
    chk("err_held", b_err, 1);

    @(negedge clk);
    b_nout_r[0] = 1'b1;
    release_a(0, "stall_release");
    idle(20);

    // Round-robin with both VCs continuously valid.
    a_nin_v = 2'b11;
    a_nin_d = {16'($urandom), 16'($urandom)};
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      for (int v = 0; v < NV; v++) if (a_acc[v]) a_nin_d[v*DW +: DW] = DW'($urandom);
      #1;
      if (ab_tvalid && ab_tready && ab_tdata[DW+VW]) begin
        if (n > 0) chk("rr_alternate", ab_tdata[DW], !prev);
        prev = ab_tdata[DW];
        n++;
      end
    end
    chk("rr_beats", n, 4);
    @(negedge clk);
    a_nin_v = '0;
    idle(20);

    // One popped flit with no TX traffic returns as a credit-only beat.
    b_nout_r[1] = 1'b0;
    send_a(1, 1, 6, got);
    chk("one_flit_sent", got, 1);
    idle(6);
    @(negedge clk);
    b_nout_r[1] = 1'b1;
    got = 0;
    for (int c = 0; c < 10 && got == 0; c++) begin
      @(negedge clk);
      #1;
      if (ba_tvalid) begin
        got = 1;
        beat = ba_tdata;
      end
    end
    chk("crd_only_seen", got, 1);
    chk("crd_only_is_data", beat[DW+VW], 0);
    chk("crd_only_vld", beat[TW-1], 1);
    chk("crd_only_vc", beat[TW-2], 1);
    idle(10);

    // Random bidirectional traffic with a reset in the middle.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (c == 200) begin
        rst = 1'b1;
        a_nin_v = '0;
        b_nin_v = '0;
        for (int q = 0; q < 4; q++) exp_q[q].delete();
      end else if (c == 201) begin
        rst = 1'b0;
        #1;
        chk("mid_rst_tvalid", {ab_tvalid, ba_tvalid}, 0);
        chk("mid_rst_tdata", {ab_tdata, ba_tdata}, 0);
        chk("mid_rst_nout_valid", {a_nout_v, b_nout_v}, 0);
        chk("mid_rst_nin_ready", {a_nin_r, b_nin_r}, 0);
        chk("mid_rst_err", {a_err, b_err}, 0);
      end else begin
        for (int v = 0; v < NV; v++) begin
          if (!a_nin_v[v] || a_acc[v]) begin
            a_nin_v[v] = 1'($urandom_range(0, 1));
            a_nin_d[v*DW +: DW] = DW'($urandom);
          end
          if (!b_nin_v[v] || b_acc[v]) begin
            b_nin_v[v] = 1'($urandom_range(0, 1));
            b_nin_d[v*DW +: DW] = DW'($urandom);
          end
          a_nout_r[v] = ($urandom_range(0, 3) != 0);
          b_nout_r[v] = ($urandom_range(0, 3) != 0);
        end
      end
    end
    @(negedge clk);
    a_nin_v = '0; b_nin_v = '0; a_nout_r = '1; b_nout_r = '1;
    idle(40);
    for (int q = 0; q < 4; q++) chk("drain_q", exp_q[q].size(), 0);

    // Credits are back at RxDepth after the mid-run reset.
    b_nout_r[1] = 1'b0;
    send_a(1, 3, 20, got);
    chk("post_rst_credit", got, RD);
    @(negedge clk);
    b_nout_r[1] = 1'b1;
    release_a(1, "post_rst_release");
    idle(30);
    for (int q = 0; q < 4; q++) chk("final_q", exp_q[q].size(), 0);
    chk("final_err", {a_err, b_err}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
